// File: rtl/quad_port_initiator_if.sv
// rtl/quad_port_initiator_if.sv - command/response and RAM port bundle for quad_port_initiator
//
// Groups both command streams (A, B), their read responses and the RAM-side
// 2-write/2-read port signals.
//   master : the initiator. It drives cmd_ready_*, rsp_* and mem_* requests,
//            and it samples cmd_* and mem_rddat_*.
//   slave  : the environment, meaning the command sources plus the RAM.
interface quad_port_initiator_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
);
    logic                  cmd_valid_a, cmd_valid_b;
    logic                  cmd_ready_a, cmd_ready_b;
    logic                  cmd_we_a,    cmd_we_b;
    logic [ADDR_WIDTH-1:0] cmd_addr_a,  cmd_addr_b;
    logic [DATA_WIDTH-1:0] cmd_wdata_a, cmd_wdata_b;
    logic [TAG_WIDTH-1:0]  cmd_tag_a,   cmd_tag_b;

    logic                  rsp_valid_a, rsp_valid_b;
    logic [DATA_WIDTH-1:0] rsp_data_a,  rsp_data_b;
    logic [TAG_WIDTH-1:0]  rsp_tag_a,   rsp_tag_b;

    logic                  mem_we_a,     mem_we_b;
    logic [ADDR_WIDTH-1:0] mem_wraddr_a, mem_wraddr_b;
    logic [DATA_WIDTH-1:0] mem_wrdat_a,  mem_wrdat_b;
    logic [ADDR_WIDTH-1:0] mem_rdaddr_a, mem_rdaddr_b;
    logic [DATA_WIDTH-1:0] mem_rddat_a,  mem_rddat_b;

    modport master (
        input  cmd_valid_a, cmd_valid_b, cmd_we_a, cmd_we_b,
        input  cmd_addr_a, cmd_addr_b, cmd_wdata_a, cmd_wdata_b,
        input  cmd_tag_a, cmd_tag_b,
        output cmd_ready_a, cmd_ready_b,
        output rsp_valid_a, rsp_valid_b, rsp_data_a, rsp_data_b,
        output rsp_tag_a, rsp_tag_b,
        output mem_we_a, mem_we_b, mem_wraddr_a, mem_wraddr_b,
        output mem_wrdat_a, mem_wrdat_b, mem_rdaddr_a, mem_rdaddr_b,
        input  mem_rddat_a, mem_rddat_b
    );

    modport slave (
        output cmd_valid_a, cmd_valid_b, cmd_we_a, cmd_we_b,
        output cmd_addr_a, cmd_addr_b, cmd_wdata_a, cmd_wdata_b,
        output cmd_tag_a, cmd_tag_b,
        input  cmd_ready_a, cmd_ready_b,
        input  rsp_valid_a, rsp_valid_b, rsp_data_a, rsp_data_b,
        input  rsp_tag_a, rsp_tag_b,
        input  mem_we_a, mem_we_b, mem_wraddr_a, mem_wraddr_b,
        input  mem_wrdat_a, mem_wrdat_b, mem_rdaddr_a, mem_rdaddr_b,
        output mem_rddat_a, mem_rddat_b
    );
endinterface

// File: rtl/quad_port_initiator.sv
// rtl/quad_port_initiator.sv - two-stream request front end for a 2W/2R quad-port RAM
//
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   bus       : quad_port_initiator_if.master. It carries the command streams
//               A and B, the tagged read responses and the RAM write/read ports.
//   init_done : high once the post-reset zero-fill of the RAM has completed
//
// After reset the block zero-fills the RAM, two words per cycle. It then
// issues commands combinationally in the cycle they are accepted. Read tags
// travel down a READ_LATENCY-deep pipeline so that each tag lines up with
// mem_rddat. Same-address hazards between the streams are resolved by
// withholding ready from one side for a cycle.
module quad_port_initiator #(
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_WORDS    = 1 << ADDR_WIDTH,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_port_initiator_if.master  bus,
    output logic                   init_done
);
    localparam int HALF = NUM_WORDS / 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  init_last;

    logic                  addr_eq, stall_a, stall_b;
    logic                  ready_a, ready_b;
    logic                  acc_a, acc_b;
    logic                  rd_acc_a, rd_acc_b, wr_acc_a, wr_acc_b;
    logic [ADDR_WIDTH-1:0] rdaddr_a_q, rdaddr_b_q;

    logic [READ_LATENCY-1:0] vld_a_q, vld_b_q;
    logic [TAG_WIDTH-1:0]    tag_a_q [READ_LATENCY];
    logic [TAG_WIDTH-1:0]    tag_b_q [READ_LATENCY];

    assign init_last = (init_cnt_q == ADDR_WIDTH'(HALF - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Zero-fill pair counter. It stops mattering once RUN is reached.
    always_ff @(posedge clk) begin
        if (rst)                   init_cnt_q <= '0;
        else if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
    end

    // Hazards are judged on the raw valids and addresses. A always wins a
    // write/write race, which makes B's write land last. A read never
    // proceeds in the same cycle as an opposing write to its address, so
    // every read sees the data that was committed before it issued.
    assign addr_eq = (bus.cmd_addr_a == bus.cmd_addr_b);
    assign stall_b = bus.cmd_valid_a & bus.cmd_we_a & bus.cmd_valid_b & addr_eq;
    assign stall_a = bus.cmd_valid_b & bus.cmd_we_b & bus.cmd_valid_a & ~bus.cmd_we_a & addr_eq;

    assign ready_a  = (state_q == ST_RUN) & ~stall_a;
    assign ready_b  = (state_q == ST_RUN) & ~stall_b;
    assign acc_a    = bus.cmd_valid_a & ready_a;
    assign acc_b    = bus.cmd_valid_b & ready_b;
    assign wr_acc_a = acc_a & bus.cmd_we_a;
    assign wr_acc_b = acc_b & bus.cmd_we_b;
    assign rd_acc_a = acc_a & ~bus.cmd_we_a;
    assign rd_acc_b = acc_b & ~bus.cmd_we_b;

    // Output logic
    always_comb begin
        bus.cmd_ready_a  = ready_a;
        bus.cmd_ready_b  = ready_b;
        init_done        = 1'b0;
        bus.mem_we_a     = 1'b0;
        bus.mem_we_b     = 1'b0;
        bus.mem_wraddr_a = bus.cmd_addr_a;
        bus.mem_wraddr_b = bus.cmd_addr_b;
        bus.mem_wrdat_a  = bus.cmd_wdata_a;
        bus.mem_wrdat_b  = bus.cmd_wdata_b;
        bus.mem_rdaddr_a = rd_acc_a ? bus.cmd_addr_a : rdaddr_a_q;
        bus.mem_rdaddr_b = rd_acc_b ? bus.cmd_addr_b : rdaddr_b_q;
        case (state_q)
            ST_INIT: begin
                bus.mem_we_a     = 1'b1;
                bus.mem_we_b     = 1'b1;
                bus.mem_wraddr_a = init_cnt_q << 1;
                bus.mem_wraddr_b = (init_cnt_q << 1) | ADDR_WIDTH'(1);
                bus.mem_wrdat_a  = '0;
                bus.mem_wrdat_b  = '0;
            end
            ST_RUN: begin
                init_done    = 1'b1;
                bus.mem_we_a = wr_acc_a;
                bus.mem_we_b = wr_acc_b;
            end
            default: ;
        endcase
    end

    // Read addresses hold their last issued value while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rdaddr_a_q <= '0;
            rdaddr_b_q <= '0;
        end else begin
            if (rd_acc_a) rdaddr_a_q <= bus.cmd_addr_a;
            if (rd_acc_b) rdaddr_b_q <= bus.cmd_addr_b;
        end
    end

    // Read-latency pipelines. Only the valid bits need reset: clearing them
    // drops any reads that are in flight when reset arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_a_q <= '0;
            vld_b_q <= '0;
        end else begin
            vld_a_q[0] <= rd_acc_a;
            vld_b_q[0] <= rd_acc_b;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_a_q[i] <= vld_a_q[i-1];
                vld_b_q[i] <= vld_b_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_a_q[0] <= bus.cmd_tag_a;
        tag_b_q[0] <= bus.cmd_tag_b;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_a_q[i] <= tag_a_q[i-1];
            tag_b_q[i] <= tag_b_q[i-1];
        end
    end

    assign bus.rsp_valid_a = vld_a_q[READ_LATENCY-1];
    assign bus.rsp_valid_b = vld_b_q[READ_LATENCY-1];
    assign bus.rsp_tag_a   = tag_a_q[READ_LATENCY-1];
    assign bus.rsp_tag_b   = tag_b_q[READ_LATENCY-1];
    assign bus.rsp_data_a  = bus.mem_rddat_a;
    assign bus.rsp_data_b  = bus.mem_rddat_b;
endmodule

// File: tb/tb_quad_port_initiator.sv
// tb/tb_quad_port_initiator.sv - randomized self-checking bench for quad_port_initiator
module tb_quad_port_initiator;
    localparam int AW   = 5;
    localparam int NW   = 1 << AW;
    localparam int DW   = 32;
    localparam int TW   = 4;
    localparam int LAT  = 2;
    localparam int HALF = NW / 2;

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } cmd_t;

    typedef struct {
        int            due;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done;

    quad_port_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    quad_port_initiator #(
        .ADDR_WIDTH(AW), .NUM_WORDS(NW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // The RAM behind the initiator: address register followed by an output
    // register. It powers up with garbage, so the zero-fill has to do real work.
    logic [DW-1:0] ram [NW];
    logic [AW-1:0] ra_a_q, ra_b_q;
    logic          seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NW; i++) ram[i] <= $urandom;
            seeded <= 1'b1;
        end else begin
            if (bus.mem_we_a) ram[bus.mem_wraddr_a] <= bus.mem_wrdat_a;
            if (bus.mem_we_b) ram[bus.mem_wraddr_b] <= bus.mem_wrdat_b;
        end
        ra_a_q          <= bus.mem_rdaddr_a;
        ra_b_q          <= bus.mem_rdaddr_b;
        bus.mem_rddat_a <= ram[ra_a_q];
        bus.mem_rddat_b <= ram[ra_b_q];
    end

    // Reference model state
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            model_k = 0;
    logic [DW-1:0] ref_mem [NW];
    rsp_t          rq [2][$];
    logic          acc [2];
    logic          rd_known [2];
    logic [AW-1:0] last_rd [2];
    int            rsp_cnt [2];
    cmd_t          cur [2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input logic v, input logic we, input int addr, input logic [DW-1:0] data, input int tag);
        cmd_t c;
        c.v = v; c.we = we; c.addr = AW'(addr); c.data = data; c.tag = TW'(tag);
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input logic v);
        int a;
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : int'($urandom_range(0, 3));
        return mk(v, 1'($urandom), a, $urandom, int'($urandom_range(0, 15)));
    endfunction

    task automatic drive(input cmd_t a, input cmd_t b);
        cur[0] = a; cur[1] = b;
        bus.cmd_valid_a = a.v; bus.cmd_we_a = a.we; bus.cmd_addr_a = a.addr;
        bus.cmd_wdata_a = a.data; bus.cmd_tag_a = a.tag;
        bus.cmd_valid_b = b.v; bus.cmd_we_b = b.we; bus.cmd_addr_b = b.addr;
        bus.cmd_wdata_b = b.data; bus.cmd_tag_b = b.tag;
    endtask

    // One clock cycle: check the outputs mid-cycle against the model, then advance.
    task automatic tick();
        logic          rdy [2], mwe [2], rv [2], eq;
        logic          exp_rdy [2];
        logic [AW-1:0] wra [2], rda [2];
        logic [DW-1:0] wrd [2], rd [2];
        logic [TW-1:0] rt [2];
        string         s;
        rsp_t          e;
        #4;
        rdy[0] = bus.cmd_ready_a;  rdy[1] = bus.cmd_ready_b;
        mwe[0] = bus.mem_we_a;     mwe[1] = bus.mem_we_b;
        wra[0] = bus.mem_wraddr_a; wra[1] = bus.mem_wraddr_b;
        wrd[0] = bus.mem_wrdat_a;  wrd[1] = bus.mem_wrdat_b;
        rda[0] = bus.mem_rdaddr_a; rda[1] = bus.mem_rdaddr_b;
        rv[0]  = bus.rsp_valid_a;  rv[1]  = bus.rsp_valid_b;
        rd[0]  = bus.rsp_data_a;   rd[1]  = bus.rsp_data_b;
        rt[0]  = bus.rsp_tag_a;    rt[1]  = bus.rsp_tag_b;
        acc[0] = 1'b0; acc[1] = 1'b0;
        if (rst) begin
            rq[0].delete(); rq[1].delete();
            model_k = 0;
            rd_known[0] = 1'b0; rd_known[1] = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                s = (p == 0) ? "a" : "b";
                if (rq[p].size() > 0 && rq[p][0].due == cyc) begin
                    e = rq[p].pop_front();
                    check({"rsp_valid_", s}, rv[p], 1'b1);
                    check({"rsp_tag_", s}, rt[p], e.tag);
                    check({"rsp_data_", s}, rd[p], e.data);
                end else begin
                    check({"rsp_idle_", s}, rv[p], 1'b0);
                end
                if (rv[p]) rsp_cnt[p]++;
            end
            if (model_k < HALF) begin
                check("init_bus",
                      {mwe[0], mwe[1], wra[0], wra[1], wrd[0], wrd[1], rdy[0], rdy[1], init_done},
                      {1'b1, 1'b1, AW'(2 * model_k), AW'(2 * model_k + 1), {DW{1'b0}}, {DW{1'b0}}, 3'b000});
                model_k++;
                if (model_k == HALF)
                    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
            end else begin
                check("init_done", init_done, 1'b1);
                eq = (cur[0].addr == cur[1].addr);
                exp_rdy[0] = !(cur[1].v && cur[1].we && cur[0].v && !cur[0].we && eq);
                exp_rdy[1] = !(cur[0].v && cur[0].we && cur[1].v && eq);
                for (int p = 0; p < 2; p++) begin
                    s = (p == 0) ? "a" : "b";
                    check({"cmd_ready_", s}, rdy[p], exp_rdy[p]);
                    acc[p] = cur[p].v & rdy[p];
                    check({"mem_we_", s}, mwe[p], acc[p] & cur[p].we);
                    if (acc[p] && cur[p].we) begin
                        check({"mem_write_", s}, {wra[p], wrd[p]}, {cur[p].addr, cur[p].data});
                    end else if (acc[p]) begin
                        check({"mem_rdaddr_", s}, rda[p], cur[p].addr);
                        e.due = cyc + LAT; e.tag = cur[p].tag; e.data = ref_mem[cur[p].addr];
                        rq[p].push_back(e);
                        last_rd[p] = cur[p].addr;
                        rd_known[p] = 1'b1;
                    end else if (rd_known[p]) begin
                        check({"rdaddr_hold_", s}, rda[p], last_rd[p]);
                    end
                end
                for (int p = 0; p < 2; p++)
                    if (acc[p] && cur[p].we) ref_mem[cur[p].addr] = cur[p].data;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(rand_cmd(1'b0), rand_cmd(1'b0));
            tick();
        end
    endtask

    // Present a command pair, holding any stalled side until accepted.
    task automatic issue(input cmd_t a, input cmd_t b);
        cmd_t ca, cb;
        int   n;
        ca = a; cb = b; n = 0;
        while ((ca.v || cb.v) && n < 6) begin
            drive(ca, cb);
            tick();
            if (acc[0]) ca.v = 1'b0;
            if (acc[1]) cb.v = 1'b0;
            n++;
        end
        check("issue_timeout", {ca.v, cb.v}, 2'b00);
    endtask

    initial begin
        cmd_t none, pa, pb;
        none = mk(1'b0, 1'b0, 0, '0, 0);
        drive(none, none);
        @(posedge clk);
        #1;
        rst = 1'b1; idle(1); rst = 1'b0;
        idle(HALF + 2);

        issue(mk(1, 1, 5, 32'hDEADBEEF, 0), none);
        issue(mk(1, 0, 9, '0, 1), mk(1, 0, 5, '0, 3));
        idle(3);

        issue(mk(1, 1, 7, 32'h11, 0), mk(1, 1, 7, 32'h22, 0));
        issue(mk(1, 0, 7, '0, 2), none);
        idle(3);

        issue(mk(1, 0, 12, '0, 4), mk(1, 1, 12, 32'h55, 0));
        issue(mk(1, 0, 13, '0, 5), mk(1, 1, 12, 32'h66, 0));
        idle(3);

        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        for (int i = 0; i < 8; i++) issue(mk(1, 0, i, '0, i), mk(1, 0, i + 8, '0, i));
        idle(4);
        check("stream_cnt_a", rsp_cnt[0], 8);
        check("stream_cnt_b", rsp_cnt[1], 8);

        issue(mk(1, 0, 3, '0, 9), mk(1, 0, 4, '0, 10));
        rst = 1'b1; idle(1); rst = 1'b0;
        idle(HALF + 2);

        pa = rand_cmd(1'b0); pb = rand_cmd(1'b0);
        for (int i = 0; i < 500; i++) begin
            if (!pa.v) pa = rand_cmd($urandom_range(0, 9) < 7);
            if (!pb.v) pb = rand_cmd($urandom_range(0, 9) < 7);
            drive(pa, pb);
            tick();
            if (acc[0] || !pa.v) pa.v = 1'b0;
            if (acc[1] || !pb.v) pb.v = 1'b0;
        end
        idle(4);
        check("rsp_drained", rq[0].size() + rq[1].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
